// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Brief    : Shared field widths, change-mask indices and default debounce count
//            for the ALU switch conditioning path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   localparam int GPIO_W = 8;
   localparam int OP_W   = 3;
   localparam int NUM_W  = 3;

   localparam int FLD_GPIO1 = 0;
   localparam int FLD_GPIO2 = 1;
   localparam int FLD_OP    = 2;
   localparam int FLD_NUM   = 3;
   localparam int FLD_CNT   = 4;

   localparam int DEBOUNCE_DEFAULT = 50000;

   typedef logic [FLD_CNT-1:0] chg_mask_t;

endpackage

`default_nettype wire

// File: rtl/alu_switch_conditioner_if.sv
//------------------------------------------------------------------------------
// Module   : alu_switch_conditioner_if
// Brief    : Raw switch inputs and conditioned ALU operand/opcode buses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_switch_conditioner_if;
   import alu_pkg::*;

   logic [GPIO_W-1:0] gpio1_raw_i;
   logic [GPIO_W-1:0] gpio2_raw_i;
   logic [OP_W-1:0]   op_raw_i;
   logic [NUM_W-1:0]  num_raw_i;

   logic [GPIO_W-1:0] reg_gpio1;
   logic [GPIO_W-1:0] reg_gpio2;
   logic [OP_W-1:0]   op_sw;
   logic [NUM_W-1:0]  num_select;
   logic              upd_o;
   chg_mask_t         changed_o;

   // master: board/stimulus side, slave: the conditioner
   modport master (
      output gpio1_raw_i, gpio2_raw_i, op_raw_i, num_raw_i,
      input  reg_gpio1, reg_gpio2, op_sw, num_select, upd_o, changed_o
   );

   modport slave (
      input  gpio1_raw_i, gpio2_raw_i, op_raw_i, num_raw_i,
      output reg_gpio1, reg_gpio2, op_sw, num_select, upd_o, changed_o
   );

endinterface

`default_nettype wire

// File: rtl/debounce_field.sv
//------------------------------------------------------------------------------
// Module   : debounce_field
// Brief    : Optional 2-flop sync (ALU_SWITCH_SYNC2_EN) plus candidate/counter
//            debounce of one switch field; commit flags the cycle out changes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_field #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             reset_sw,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] out,
   output logic             commit
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] cand;
   logic [CNT_W-1:0] cnt;

`ifdef ALU_SWITCH_SYNC2_EN
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk_i) begin
      if (reset_sw) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   assign s = sync2;
`else
   assign s = raw;
`endif

   // Same condition as the commit branch below, exposed so the top can
   // register the strobe on the very edge that out changes.
   assign commit = (s == cand) && (cnt == CNT_MAX) && (cand != out);

   always_ff @(posedge clk_i) begin
      if (reset_sw) begin
         cand <= '0;
         cnt  <= '0;
         out  <= '0;
      end else if (s != cand) begin
         cand <= s;
         cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end else if (cand != out) begin
         out <= cand;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_switch_conditioner.sv
//------------------------------------------------------------------------------
// Module   : alu_switch_conditioner
// Brief    : Four independent debounced switch fields with a one-cycle update
//            strobe and change mask. Define ALU_SWITCH_SYNC2_EN for board builds.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_switch_conditioner
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     reset_sw,
   alu_switch_conditioner_if.slave  sw
);

   chg_mask_t commit;
   chg_mask_t changed;
   logic      upd;

   debounce_field #(.WIDTH(GPIO_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gpio1 (
      .clk_i    (clk_i),
      .reset_sw (reset_sw),
      .raw      (sw.gpio1_raw_i),
      .out      (sw.reg_gpio1),
      .commit   (commit[FLD_GPIO1])
   );

   debounce_field #(.WIDTH(GPIO_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gpio2 (
      .clk_i    (clk_i),
      .reset_sw (reset_sw),
      .raw      (sw.gpio2_raw_i),
      .out      (sw.reg_gpio2),
      .commit   (commit[FLD_GPIO2])
   );

   debounce_field #(.WIDTH(OP_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_op (
      .clk_i    (clk_i),
      .reset_sw (reset_sw),
      .raw      (sw.op_raw_i),
      .out      (sw.op_sw),
      .commit   (commit[FLD_OP])
   );

   debounce_field #(.WIDTH(NUM_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_num (
      .clk_i    (clk_i),
      .reset_sw (reset_sw),
      .raw      (sw.num_raw_i),
      .out      (sw.num_select),
      .commit   (commit[FLD_NUM])
   );

   // Registered alongside the field outputs, so the mask is zero whenever upd is.
   always_ff @(posedge clk_i) begin
      if (reset_sw) begin
         upd     <= 1'b0;
         changed <= '0;
      end else begin
         upd     <= |commit;
         changed <= commit;
      end
   end

   assign sw.upd_o     = upd;
   assign sw.changed_o = changed;

endmodule

`default_nettype wire

// File: tb/tb_alu_switch_conditioner.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_switch_conditioner
// Brief    : Directed-vector bench for alu_switch_conditioner, DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_switch_conditioner;
   import alu_pkg::*;

   localparam int DC = 4;
`ifdef ALU_SWITCH_SYNC2_EN
   localparam int LAT = DC + 2;
`else
   localparam int LAT = DC;
`endif

   logic clk_i    = 1'b0;
   logic reset_sw = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   alu_switch_conditioner_if sw ();

   alu_switch_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk_i    (clk_i),
      .reset_sw (reset_sw),
      .sw       (sw)
   );

   always #5 clk_i = ~clk_i;

   // {gpio1, gpio2, op, num, upd, changed}
   logic [26:0] obs;
   assign obs = {sw.reg_gpio1, sw.reg_gpio2, sw.op_sw, sw.num_select, sw.upd_o, sw.changed_o};

   logic [7:0] e_g1  = 8'h00;
   logic [7:0] e_g2  = 8'h00;
   logic [2:0] e_op  = 3'd0;
   logic [2:0] e_num = 3'd0;

   function automatic logic [26:0] expv(input logic [3:0] chg);
      return {e_g1, e_g2, e_op, e_num, |chg, chg};
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_sw       = 1'b1;
      sw.gpio1_raw_i = 8'h00;
      sw.gpio2_raw_i = 8'h00;
      sw.op_raw_i    = 3'd0;
      sw.num_raw_i   = 3'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (obs !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d: got %h expected %h", i, obs, 27'd0);
         end
      end
      reset_sw = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         vectors++;
         if (obs !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_idle cyc%0d: got %h expected %h", i, obs, 27'd0);
         end
      end
   endtask

   task automatic test_gpio1_commit();
      sw.gpio1_raw_i = 8'hA5;
      for (int i = 0; i < LAT; i++) begin
         step();
         vectors++;
         if (obs !== expv(4'b0000)) begin
            miscompares++;
            $display("FAIL gpio1_wait cyc%0d: got %h expected %h", i, obs, expv(4'b0000));
         end
      end
      step();
      e_g1 = 8'hA5;
      vectors++;
      if (obs !== expv(4'b0001)) begin
         miscompares++;
         $display("FAIL gpio1_commit: got %h expected %h", obs, expv(4'b0001));
      end
      step();
      vectors++;
      if (obs !== expv(4'b0000)) begin
         miscompares++;
         $display("FAIL gpio1_after: got %h expected %h", obs, expv(4'b0000));
      end
   endtask

   task automatic test_op_bounce();
      logic [2:0] seq [3] = '{3'd3, 3'd0, 3'd3};
      for (int k = 0; k < 2; k++) begin
         sw.op_raw_i = seq[k];
         for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (obs !== expv(4'b0000)) begin
               miscompares++;
               $display("FAIL op_toggle k%0d cyc%0d: got %h expected %h", k, i, obs, expv(4'b0000));
            end
         end
      end
      sw.op_raw_i = seq[2];
      for (int i = 0; i < LAT; i++) begin
         step();
         vectors++;
         if (obs !== expv(4'b0000)) begin
            miscompares++;
            $display("FAIL op_settle cyc%0d: got %h expected %h", i, obs, expv(4'b0000));
         end
      end
      step();
      e_op = 3'd3;
      vectors++;
      if (obs !== expv(4'b0100)) begin
         miscompares++;
         $display("FAIL op_commit: got %h expected %h", obs, expv(4'b0100));
      end
      step();
      vectors++;
      if (obs !== expv(4'b0000)) begin
         miscompares++;
         $display("FAIL op_after: got %h expected %h", obs, expv(4'b0000));
      end
   endtask

   task automatic test_num_glitch();
      sw.num_raw_i = 3'd2;
      repeat (LAT) step();
      step();
      e_num = 3'd2;
      vectors++;
      if (obs !== expv(4'b1000)) begin
         miscompares++;
         $display("FAIL num_commit: got %h expected %h", obs, expv(4'b1000));
      end
      sw.num_raw_i = 3'd5;
      repeat (3) step();
      sw.num_raw_i = 3'd2;
      for (int i = 0; i < 2 * LAT + 2; i++) begin
         step();
         vectors++;
         if (obs !== expv(4'b0000)) begin
            miscompares++;
            $display("FAIL num_glitch cyc%0d: got %h expected %h", i, obs, expv(4'b0000));
         end
      end
   endtask

   task automatic test_simultaneous();
      sw.gpio2_raw_i = 8'h3C;
      sw.op_raw_i    = 3'd5;
      for (int i = 0; i < LAT; i++) begin
         step();
         vectors++;
         if (obs !== expv(4'b0000)) begin
            miscompares++;
            $display("FAIL simul_wait cyc%0d: got %h expected %h", i, obs, expv(4'b0000));
         end
      end
      step();
      e_g2 = 8'h3C;
      e_op = 3'd5;
      vectors++;
      if (obs !== expv(4'b0110)) begin
         miscompares++;
         $display("FAIL simul_commit: got %h expected %h", obs, expv(4'b0110));
      end
      step();
      vectors++;
      if (obs !== expv(4'b0000)) begin
         miscompares++;
         $display("FAIL simul_after: got %h expected %h", obs, expv(4'b0000));
      end
   endtask

   task automatic test_mid_reset();
      sw.gpio1_raw_i = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (obs !== expv(4'b0000)) begin
            miscompares++;
            $display("FAIL midrst_pre cyc%0d: got %h expected %h", i, obs, expv(4'b0000));
         end
      end
      reset_sw       = 1'b1;
      sw.gpio2_raw_i = 8'h00;
      sw.op_raw_i    = 3'd0;
      sw.num_raw_i   = 3'd0;
      step();
      e_g1  = 8'h00;
      e_g2  = 8'h00;
      e_op  = 3'd0;
      e_num = 3'd0;
      vectors++;
      if (obs !== 27'd0) begin
         miscompares++;
         $display("FAIL midrst_clear: got %h expected %h", obs, 27'd0);
      end
      reset_sw = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         step();
         vectors++;
         if (obs !== expv(4'b0000)) begin
            miscompares++;
            $display("FAIL midrst_wait cyc%0d: got %h expected %h", i, obs, expv(4'b0000));
         end
      end
      step();
      e_g1 = 8'hFF;
      vectors++;
      if (obs !== expv(4'b0001)) begin
         miscompares++;
         $display("FAIL midrst_commit: got %h expected %h", obs, expv(4'b0001));
      end
      step();
      vectors++;
      if (obs !== expv(4'b0000)) begin
         miscompares++;
         $display("FAIL midrst_after: got %h expected %h", obs, expv(4'b0000));
      end
   endtask

   initial begin
      test_reset();
      test_gpio1_commit();
      test_op_bounce();
      test_num_glitch();
      test_simultaneous();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
